// File: rtl/csa_pipe.sv
// csa_pipe: two-stage pipelined carry-select adder/subtractor with valid/ready backpressure.
// Define CSA_OVF_EN to add the registered signed-overflow output ovf.
module csa_pipe #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int N = WIDTH / BLK;

    if (WIDTH % BLK != 0) begin : g_bad_width
        $error("csa_pipe: WIDTH must be a multiple of BLK");
    end

    logic [WIDTH-1:0]       bx;
    logic                   c0;
    logic [N-1:0][BLK:0]    p0, p1;
    logic [N-1:0][BLK:0]    r0, r1;
    logic                   c0_r;
    logic                   s1_valid;
    logic                   adv2;
    logic [WIDTH-1:0]       sum_n;
    logic                   cout_n;
    logic                   cc;
`ifdef CSA_OVF_EN
    logic                   a_msb, bx_msb;
`endif

    assign bx       = sub ? ~b : b;
    assign c0       = sub ? 1'b1 : cin;
    assign adv2     = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv2;

    // Both conditional block sums, each carrying its own block carry-out in the MSB.
    always_comb begin
        p0 = '0;
        p1 = '0;
        for (int k = 0; k < N; k++) begin
            p0[k] = {1'b0, a[k*BLK +: BLK]} + {1'b0, bx[k*BLK +: BLK]};
            p1[k] = p0[k] + (BLK+1)'(1);
        end
    end

    // Select chain: each block's carry-in picks its precomputed pair.
    always_comb begin
        cc    = c0_r;
        sum_n = '0;
        for (int k = 0; k < N; k++) begin
            sum_n[k*BLK +: BLK] = cc ? r1[k][BLK-1:0] : r0[k][BLK-1:0];
            cc = cc ? r1[k][BLK] : r0[k][BLK];
        end
        cout_n = cc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            r0       <= '0;
            r1       <= '0;
            c0_r     <= 1'b0;
`ifdef CSA_OVF_EN
            a_msb    <= 1'b0;
            bx_msb   <= 1'b0;
`endif
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                r0   <= p0;
                r1   <= p1;
                c0_r <= c0;
`ifdef CSA_OVF_EN
                a_msb  <= a[WIDTH-1];
                bx_msb <= bx[WIDTH-1];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef CSA_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_n;
                cout <= cout_n;
`ifdef CSA_OVF_EN
                ovf  <= (a_msb == bx_msb) && (sum_n[WIDTH-1] != a_msb);
`endif
            end
        end
    end
endmodule

// File: tb/tb_csa_pipe.sv
// tb_csa_pipe: directed vectors and handshake sequences on a 32/8 instance,
// plus a random lockstep sweep over 32/8, 16/4 and 64/16 instances.
module tb_csa_pipe;
    logic clk = 0;
    logic rst, in_valid, out_ready, sub, cin;
    logic [31:0] a32, b32, sum32;
    logic [15:0] a16, b16, sum16;
    logic [63:0] a64, b64, sum64;
    logic rdy32, rdy16, rdy64, ov32, ov16, ov64, co32, co16, co64;
`ifdef CSA_OVF_EN
    logic ovf32, ovf16, ovf64;
`endif
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    csa_pipe #(.WIDTH(32), .BLK(8)) u32 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .a(a32), .b(b32), .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(out_ready), .sum(sum32), .cout(co32)
`ifdef CSA_OVF_EN
        , .ovf(ovf32)
`endif
    );
    csa_pipe #(.WIDTH(16), .BLK(4)) u16 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
        .a(a16), .b(b16), .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready), .sum(sum16), .cout(co16)
`ifdef CSA_OVF_EN
        , .ovf(ovf16)
`endif
    );
    csa_pipe #(.WIDTH(64), .BLK(16)) u64 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .a(a64), .b(b64), .cin(cin), .sub(sub), .out_valid(ov64), .out_ready(out_ready), .sum(sum64), .cout(co64)
`ifdef CSA_OVF_EN
        , .ovf(ovf64)
`endif
    );

    typedef struct {
        logic        sub;
        logic        cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, returns {cout, 64-bit zero-extended sum}.
    function automatic logic [64:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic s, input logic c);
        logic [63:0] mask;
        logic [64:0] r;
        mask = (w == 64) ? '1 : (64'(1) << w) - 64'(1);
        r = {1'b0, x & mask} + {1'b0, (s ? ~y : y) & mask} + 65'(s ? 1'b1 : c);
        return {r[w], r[63:0] & mask};
    endfunction

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y, input logic s, input logic c);
        in_valid = v; a32 = x; b32 = y; sub = s; cin = c;
    endtask

    vec_t vecs[9];
    logic [64:0] q32[$], q16[$], q64[$];
    logic        qo[$];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h000000FF, 32'h00000000, 32'h00000100, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 32'h12345678, 32'h0FEDCBA9, 32'h22222221, 1'b0, 1'b0};
        rst = 1; out_ready = 1; a16 = 0; b16 = 0; a64 = 0; b64 = 0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("reset out_valid", 65'(ov32), 65'(0));
        chk("reset sum", 65'(sum32), 65'(0));
        chk("reset cout", 65'(co32), 65'(0));
        chk("reset in_ready", 65'(rdy32), 65'(1));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            @(negedge clk);
            in_valid = 0;
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), 65'(ov32), 65'(1));
            chk($sformatf("vec%0d sum", i), 65'(sum32), 65'(vecs[i].sum));
            chk($sformatf("vec%0d cout", i), 65'(co32), 65'(vecs[i].cout));
`ifdef CSA_OVF_EN
            chk($sformatf("vec%0d ovf", i), 65'(ovf32), 65'(vecs[i].ovf));
`endif
        end

        // Backpressure: three beats offered with the sink stalled.
        @(negedge clk);
        out_ready = 0;
        drive(1, 1, 1, 0, 0);
        #1 chk("bp in_ready beat1", 65'(rdy32), 65'(1));
        @(negedge clk);
        drive(1, 2, 2, 0, 0);
        #1 chk("bp in_ready beat2", 65'(rdy32), 65'(1));
        @(negedge clk);
        drive(1, 3, 3, 0, 0);
        #1 chk("bp in_ready full", 65'(rdy32), 65'(0));
        chk("bp out_valid", 65'(ov32), 65'(1));
        chk("bp sum held", 65'(sum32), 65'(2));
        @(negedge clk);
        #1 chk("bp sum still held", 65'(sum32), 65'(2));
        chk("bp in_ready still 0", 65'(rdy32), 65'(0));
        out_ready = 1;
        #1 chk("bp in_ready on release", 65'(rdy32), 65'(1));
        @(negedge clk);
        in_valid = 0;
        #1 chk("bp second sum", 65'(sum32), 65'(4));
        chk("bp second valid", 65'(ov32), 65'(1));
        @(negedge clk);
        #1 chk("bp third sum", 65'(sum32), 65'(6));
        chk("bp third valid", 65'(ov32), 65'(1));
        @(negedge clk);
        #1 chk("bp drained", 65'(ov32), 65'(0));

        // Reset with two beats in flight.
        out_ready = 0;
        drive(1, 9, 9, 0, 0);
        @(negedge clk);
        drive(1, 10, 10, 0, 0);
        @(negedge clk);
        in_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1 chk("mid-rst out_valid", 65'(ov32), 65'(0));
        chk("mid-rst sum", 65'(sum32), 65'(0));
        chk("mid-rst in_ready", 65'(rdy32), 65'(1));
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("mid-rst no stale", 65'(ov32), 65'(0));
        end

        // Random lockstep sweep with random backpressure.
        rst = 1;
        @(negedge clk);
        rst = 0;
        begin
            int sent = 0, cyc = 0;
            while ((sent < 1000 || q32.size() != 0 || q16.size() != 0 || q64.size() != 0) && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
                out_ready = $urandom_range(0, 3) != 0;
                sub = 1'($urandom); cin = 1'($urandom);
                a32 = $urandom; b32 = $urandom;
                a16 = 16'($urandom); b16 = 16'($urandom);
                a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) b32 = ~a32;
                #1;
                if (ov32 && out_ready) begin
                    if (q32.size() == 0) chk("rnd32 spurious", 65'(ov32), 65'(0));
                    else begin
                        chk("rnd32", {co32, 32'h0, sum32}, q32.pop_front());
`ifdef CSA_OVF_EN
                        chk("rnd32 ovf", 65'(ovf32), 65'(qo[0]));
`endif
                        void'(qo.pop_front());
                    end
                end
                if (ov16 && out_ready) begin
                    if (q16.size() == 0) chk("rnd16 spurious", 65'(ov16), 65'(0));
                    else chk("rnd16", {co16, 48'h0, sum16}, q16.pop_front());
                end
                if (ov64 && out_ready) begin
                    if (q64.size() == 0) chk("rnd64 spurious", 65'(ov64), 65'(0));
                    else chk("rnd64", {co64, sum64}, q64.pop_front());
                end
                if (in_valid && rdy32) begin
                    logic [64:0] r;
                    logic [31:0] bx;
                    r = model(32, 64'(a32), 64'(b32), sub, cin);
                    bx = sub ? ~b32 : b32;
                    q32.push_back(r);
                    qo.push_back((a32[31] == bx[31]) && (r[31] != a32[31]));
                    sent++;
                end
                if (in_valid && rdy16) q16.push_back(model(16, 64'(a16), 64'(b16), sub, cin));
                if (in_valid && rdy64) q64.push_back(model(64, a64, b64, sub, cin));
            end
            if (cyc >= 20000) chk("rnd timeout", 65'(q32.size() + q16.size() + q64.size()), 65'(0));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
